// File: rtl/pong_menu_ctrl_if.sv
// Read bus between the menu controller and the shared menu-item ROM.
// The controller drives the address; the ROM returns data one cycle later.
interface pong_menu_ctrl_if;
  logic [9:0] rom_row;
  logic [9:0] rom_col;
  logic [7:0] rom_data;

  modport master (output rom_row, output rom_col, input rom_data);
  modport slave  (input rom_row, input rom_col, output rom_data);
endinterface

// File: rtl/pong_menu_ctrl.sv
// Pong start-screen menu: maps the beam onto the shared item ROM, colours and
// highlights the selected slot, and runs the button-driven selection FSM.
module pong_menu_ctrl #(
  parameter int N_ITEMS = 3,
  parameter int ITEM_W  = 64,
  parameter int ITEM_H  = 16,
  parameter int X0      = 288,
  parameter int Y0      = 200,
  parameter int PITCH   = 24,
  parameter logic [7:0] HILITE_BG = 8'b00000011,
  parameter logic [7:0] DIM_MASK  = 8'b01101101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       menu_active,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  pong_menu_ctrl_if.master rom,
  output logic [7:0] rgb_out,
  output logic       pixel_hit,
  output logic [1:0] sel_item,
  output logic       start_pulse
);

  typedef enum logic [1:0] {IDLE, MENU, LAUNCH, HOLD} state_t;

  localparam logic [9:0] X_LO     = 10'(X0);
  localparam logic [9:0] X_HI     = 10'(X0 + ITEM_W);
  localparam logic [1:0] LAST_SEL = 2'(N_ITEMS - 1);

  // ---------------- slot decode ----------------
  logic             x_in;
  logic [N_ITEMS-1:0] slot_hit;
  logic [9:0]       slot_row [N_ITEMS];

  assign x_in = (pixel_x >= X_LO) && (pixel_x < X_HI);

  for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_slot
    localparam logic [9:0] TOP  = 10'(Y0 + gi * PITCH);
    localparam logic [9:0] BOT  = 10'(Y0 + gi * PITCH + ITEM_H);
    localparam logic [9:0] BASE = 10'(gi * ITEM_H);
    assign slot_hit[gi] = x_in && (pixel_y >= TOP) && (pixel_y < BOT);
    // Only meaningful when slot_hit[gi]; otherwise the subtraction may wrap.
    assign slot_row[gi] = BASE + (pixel_y - TOP);
  end

  logic       hit_c;
  logic [1:0] idx_c;
  logic [9:0] row_c;
  logic [9:0] col_c;

  always_comb begin
    hit_c = 1'b0;
    idx_c = 2'd0;
    row_c = 10'd0;
    col_c = 10'd0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (slot_hit[i]) begin
        hit_c = 1'b1;
        idx_c = 2'(i);
        row_c = slot_row[i];
      end
    end
    if (hit_c) begin
      col_c = pixel_x - X_LO;
    end
  end

  assign rom.rom_row = row_c;
  assign rom.rom_col = col_c;

  // ---------------- registers ----------------
  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       start_q, start_d;
  logic       up_prev_q, down_prev_q, sel_prev_q;
  logic       hit_q, vid_q;
  logic [1:0] idx_q;
  logic [7:0] rgb_q, rgb_d;
  logic       pix_hit_q, pix_hit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      start_q     <= 1'b0;
      up_prev_q   <= 1'b1;
      down_prev_q <= 1'b1;
      sel_prev_q  <= 1'b1;
      hit_q       <= 1'b0;
      idx_q       <= 2'd0;
      vid_q       <= 1'b0;
      rgb_q       <= 8'd0;
      pix_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      up_prev_q   <= btn_up;
      down_prev_q <= btn_down;
      sel_prev_q  <= btn_sel;
      hit_q       <= hit_c;
      idx_q       <= idx_c;
      vid_q       <= video_on;
      rgb_q       <= rgb_d;
      pix_hit_q   <= pix_hit_d;
    end
  end

  // ---------------- selection FSM ----------------
  logic up_edge, down_edge, sel_edge;

  assign up_edge   = btn_up   & ~up_prev_q;
  assign down_edge = btn_down & ~down_prev_q;
  assign sel_edge  = btn_sel  & ~sel_prev_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (menu_active) begin
          state_d = MENU;
          sel_d   = 2'd0;
        end
      end
      MENU: begin
        if (!menu_active) begin
          state_d = IDLE;
        end else if (sel_edge) begin
          // Select beats any navigation edge in the same cycle.
          state_d = LAUNCH;
          start_d = 1'b1;
        end else if (up_edge && !down_edge) begin
          sel_d = (sel_q == 2'd0) ? LAST_SEL : sel_q - 2'd1;
        end else if (down_edge && !up_edge) begin
          sel_d = (sel_q == LAST_SEL) ? 2'd0 : sel_q + 2'd1;
        end
      end
      LAUNCH: state_d = HOLD;
      HOLD: begin
        if (!menu_active) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output colour stage ----------------
  always_comb begin
    rgb_d     = 8'd0;
    pix_hit_d = hit_q & vid_q & (state_q == MENU);
    if (pix_hit_d) begin
      if (idx_q == sel_q) begin
        rgb_d = (rom.rom_data == 8'd0) ? HILITE_BG : rom.rom_data;
      end else begin
        rgb_d = rom.rom_data & DIM_MASK;
      end
    end
  end

  assign rgb_out     = rgb_q;
  assign pixel_hit   = pix_hit_q;
  assign sel_item    = sel_q;
  assign start_pulse = start_q;

endmodule

// File: tb/tb_pong_menu_ctrl.sv
// Directed bench for pong_menu_ctrl: expected values are queued at drive time
// and popped when the corresponding DUT output is due.
module tb_pong_menu_ctrl;

  localparam int X0 = 288;
  localparam int Y0 = 200;
  localparam int ITEM_W = 64;
  localparam int ITEM_H = 16;
  localparam int PITCH = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       menu_active;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       btn_up, btn_down, btn_sel;
  logic [7:0] rgb_out;
  logic       pixel_hit;
  logic [1:0] sel_item;
  logic       start_pulse;
  logic [7:0] rom_fill;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  pong_menu_ctrl_if rom_if ();

  pong_menu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .menu_active (menu_active),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_sel     (btn_sel),
    .rom         (rom_if.master),
    .rgb_out     (rgb_out),
    .pixel_hit   (pixel_hit),
    .sel_item    (sel_item),
    .start_pulse (start_pulse)
  );

  always #5 clk = ~clk;

  // ROM model: one-cycle registered read returning the current fill value.
  always @(posedge clk) rom_if.rom_data <= rom_fill;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One button transaction: drive, check after the sampling edge, release.
  task automatic press(input logic u, input logic d, input logic s,
                       input logic [1:0] exp_sel, input logic exp_start, input string tag);
    logic [15:0] e;
    btn_up = u; btn_down = d; btn_sel = s;
    exp_q.push_back({13'd0, exp_start, exp_sel});
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {13'd0, start_pulse, sel_item}, e);
    $display("press up=%0b down=%0b sel=%0b -> sel_item=%0d start_pulse=%0b", u, d, s, sel_item, start_pulse);
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    @(negedge clk);
  endtask

  // One pixel transaction: address checked at once, colour two edges later.
  task automatic pix(input int x, input int y, input logic vid, input logic [7:0] fill,
                     input logic [9:0] exp_row, input logic [9:0] exp_col,
                     input logic exp_hit, input logic [7:0] exp_rgb, input string tag);
    logic [15:0] e;
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid; rom_fill = fill;
    exp_q.push_back({7'd0, exp_hit, exp_rgb});
    #1;
    chk({tag, "_row"}, {6'd0, rom_if.rom_row}, {6'd0, exp_row});
    chk({tag, "_col"}, {6'd0, rom_if.rom_col}, {6'd0, exp_col});
    @(negedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "_rgb"}, {7'd0, pixel_hit, rgb_out}, e);
    $display("pixel (%0d,%0d) row=%0d col=%0d -> hit=%0b rgb=%02h", x, y, exp_row, exp_col, pixel_hit, rgb_out);
  endtask

  initial begin
    reset = 1'b1; menu_active = 1'b0; video_on = 1'b1;
    pixel_x = 10'd0; pixel_y = 10'd0; rom_fill = 8'h00;
    btn_up = 1'b0; btn_down = 1'b1; btn_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {5'd0, start_pulse, sel_item, rgb_out}, 16'd0);
    chk("reset_hit", {15'd0, pixel_hit}, 16'd0);

    // Held button through reset and into MENU must not fire.
    reset = 1'b0; menu_active = 1'b1;
    repeat (2) @(negedge clk);
    chk("held_down", {14'd0, sel_item}, 16'd0);
    btn_down = 1'b0;
    @(negedge clk);
    chk("released_down", {14'd0, sel_item}, 16'd0);
    press(0, 1, 0, 2'd1, 0, "down_0_to_1");
    press(0, 0, 0, 2'd1, 0, "no_button");
    press(1, 0, 0, 2'd0, 0, "up_1_to_0");
    press(1, 0, 0, 2'd2, 0, "up_wrap_0_to_2");
    press(0, 1, 0, 2'd0, 0, "down_wrap_2_to_0");
    press(0, 1, 0, 2'd1, 0, "down_0_to_1b");
    press(0, 1, 0, 2'd2, 0, "down_1_to_2");
    press(0, 1, 0, 2'd0, 0, "down_2_to_0b");
    press(0, 1, 0, 2'd1, 0, "down_0_to_1c");
    press(1, 1, 0, 2'd1, 0, "up_down_same");

    // Pixel path with sel_item=1.
    pix(X0 + 5, Y0 + PITCH + 3, 1, 8'hFF, 10'd19, 10'd5, 1, 8'hFF, "slot1_sel_ff");
    pix(X0 + 5, Y0 + PITCH + 3, 1, 8'h00, 10'd19, 10'd5, 1, 8'h03, "slot1_sel_zero");
    pix(X0 + 5, Y0 + 3, 1, 8'hFF, 10'd3, 10'd5, 1, 8'h6D, "slot0_dim");
    pix(X0 + ITEM_W, Y0, 1, 8'hFF, 10'd0, 10'd0, 0, 8'h00, "right_edge");
    pix(X0 + 5, Y0 + ITEM_H, 1, 8'hFF, 10'd0, 10'd0, 0, 8'h00, "gap_row");
    pix(X0 - 1, Y0 + 4, 1, 8'hFF, 10'd0, 10'd0, 0, 8'h00, "left_edge");
    pix(X0 + ITEM_W - 1, Y0 + 2 * PITCH + ITEM_H - 1, 1, 8'hA7, 10'd47, 10'd63, 1, 8'h25, "slot2_corner");
    pix(X0 + 5, Y0 + PITCH + 3, 0, 8'hFF, 10'd19, 10'd5, 0, 8'h00, "blanked");

    press(1, 0, 0, 2'd0, 0, "up_1_to_0b");
    pix(X0 + 5, Y0 + PITCH + 3, 1, 8'hFF, 10'd19, 10'd5, 1, 8'h6D, "slot1_unsel");
    press(0, 1, 0, 2'd1, 0, "down_0_to_1d");

    // Select together with down: select wins, pre-edge item launched.
    press(0, 1, 1, 2'd1, 1, "sel_with_down");
    chk("pulse_one_cycle", {15'd0, start_pulse}, 16'd0);
    press(0, 1, 0, 2'd1, 0, "hold_ignores_down");
    press(0, 0, 1, 2'd1, 0, "hold_ignores_sel");
    pix(X0 + 5, Y0 + PITCH + 3, 1, 8'hFF, 10'd19, 10'd5, 0, 8'h00, "hold_no_pixel");

    // Leave and re-enter menu: selection cleared on entry.
    menu_active = 1'b0;
    @(negedge clk);
    menu_active = 1'b1;
    @(negedge clk);
    chk("reentry_sel", {14'd0, sel_item}, 16'd0);

    // Falling menu_active: one more coloured pixel, then black.
    pix(X0 + 5, Y0 + 3, 1, 8'hFF, 10'd3, 10'd5, 1, 8'hFF, "slot0_sel");
    menu_active = 1'b0;
    @(negedge clk);
    chk("fall_last_pixel", {7'd0, pixel_hit, rgb_out}, 16'h01FF);
    @(negedge clk);
    chk("fall_black", {7'd0, pixel_hit, rgb_out}, 16'h0000);

    // Reset during LAUNCH cancels the pulse.
    menu_active = 1'b1;
    @(negedge clk);
    press(1, 0, 0, 2'd2, 0, "up_to_2");
    btn_sel = 1'b1;
    @(negedge clk);
    chk("launch_pulse", {13'd0, start_pulse, sel_item}, 16'h0006);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_launch", {5'd0, start_pulse, sel_item, rgb_out}, 16'd0);
    reset = 1'b0; menu_active = 1'b0; btn_sel = 1'b0;
    @(negedge clk);
    press(0, 0, 1, 2'd0, 0, "idle_ignores_sel");
    chk("idle_no_pulse", {15'd0, start_pulse}, 16'd0);
    menu_active = 1'b1;
    @(negedge clk);
    press(0, 0, 1, 2'd0, 1, "menu_sel_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
